// File: rtl/zc_pkg.sv
// zc_pkg: shared lane geometry, entry/event types and output-state encoding for the zero-crossing serializer
package zc_pkg;
    localparam int NUM_CHANNELS = 16;
    localparam int LANE_W = $clog2(NUM_CHANNELS);
    localparam int ZC_TS_WIDTH = 32;

    typedef struct packed {
        logic [ZC_TS_WIDTH-1:0]  beat;
        logic [NUM_CHANNELS-1:0] mask;
    } zc_entry_t;

    typedef struct packed {
        logic [ZC_TS_WIDTH+LANE_W-1:0] ts;
        logic                          last;
    } zc_event_t;

    typedef enum logic {
        ZC_EMPTY,
        ZC_PRESENT
    } zc_out_state_t;
endpackage

// File: rtl/zc_mask_fifo.sv
// zc_mask_fifo: synchronous FIFO with registered full/empty; a push is accepted when full if a pop happens in the same cycle
module zc_mask_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, cnt_nx;
    logic          wr, rd;

    assign rd     = pop && !empty;
    assign wr     = push && (!full || rd);
    assign cnt_nx = cnt + (AW+1)'(wr) - (AW+1)'(rd);
    assign dout   = mem[rd_ptr];

    // pointers, occupancy and the registered full/empty flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr);
            rd_ptr <= rd_ptr + AW'(rd);
            cnt    <= cnt_nx;
            full   <= cnt_nx == (AW+1)'(DEPTH);
            empty  <= cnt_nx == '0;
        end
    end

    // storage array, written without reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/zc_event_serializer.sv
// zc_event_serializer: turns per-beat zero-crossing masks into a serial stream of timestamped events (optional ZC_EVT_DROPCNT_EN adds drop_count)
module zc_event_serializer
    import zc_pkg::*;
#(
    parameter int TS_WIDTH   = ZC_TS_WIDTH,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [NUM_CHANNELS-1:0]    zero_mask_in,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [TS_WIDTH+LANE_W-1:0] evt_time,
    output logic                       evt_last,
    output logic                       overflow,
    input  logic                       clear_overflow
`ifdef ZC_EVT_DROPCNT_EN
    ,
    output logic [15:0]                drop_count
`endif
);
    zc_out_state_t                      state, state_nx;
    logic [TS_WIDTH-1:0]                beat_cnt, out_beat;
    logic [NUM_CHANNELS-1:0]            out_mask;
    logic [LANE_W-1:0]                  lane;
    logic [TS_WIDTH+NUM_CHANNELS-1:0]   fifo_dout;
    logic                               fifo_full, fifo_empty;
    logic                               push, pop, accept, last, drop;

    assign push      = valid_in && (zero_mask_in != '0);
    assign evt_valid = state == ZC_PRESENT;
    assign accept    = evt_valid && evt_ready;
    assign last      = (out_mask != '0) && ((out_mask & (out_mask - NUM_CHANNELS'(1))) == '0);
    assign pop       = !fifo_empty && (!evt_valid || (accept && last));
    assign drop      = push && fifo_full && !pop;
    assign evt_time  = {out_beat, lane};
    assign evt_last  = last;

    zc_mask_fifo #(.W(TS_WIDTH + NUM_CHANNELS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({beat_cnt, zero_mask_in}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // lowest set residual bit is the earliest remaining crossing
    always_comb begin
        lane = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (out_mask[i]) lane = LANE_W'(i);
    end

    // output-slot occupancy: leaves PRESENT only when the final bit goes and nothing is queued
    always_comb begin
        state_nx = (state == ZC_EMPTY) ? (fifo_empty ? ZC_EMPTY : ZC_PRESENT)
                                       : ((accept && last && fifo_empty) ? ZC_EMPTY : ZC_PRESENT);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ZC_EMPTY;
        else     state <= state_nx;
    end

    // beat counter plus the output entry: reload on pop, otherwise retire one lane per accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            out_beat <= '0;
            out_mask <= '0;
        end else begin
            if (valid_in) beat_cnt <= beat_cnt + TS_WIDTH'(1);
            if (pop) {out_beat, out_mask} <= fifo_dout;
            else if (accept) out_mask <= out_mask & (out_mask - NUM_CHANNELS'(1));
        end
    end

    // sticky overflow, a same-cycle drop beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 overflow <= 1'b0;
        else if (drop)           overflow <= 1'b1;
        else if (clear_overflow) overflow <= 1'b0;
    end

`ifdef ZC_EVT_DROPCNT_EN
    // saturating dropped-beat counter, restarted by clear_overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                drop_count <= '0;
        else if (clear_overflow)                drop_count <= {15'd0, drop};
        else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_zc_event_serializer.sv
// tb_zc_event_serializer: directed and random checks of the serializer (TS_WIDTH=4) against a queue-based event model
module tb_zc_event_serializer;
    localparam int TW = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [15:0] zero_mask_in = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [TW+3:0] evt_time;
    logic        evt_last;
    logic        overflow;
    logic        clear_overflow = 1'b0;
`ifdef ZC_EVT_DROPCNT_EN
    logic [15:0] drop_count;
`endif

    int total = 0;
    int bad = 0;

    typedef struct {
        int          beat;
        logic [15:0] mask;
    } ent_t;

    ent_t        q[$];
    logic        m_valid;
    int          m_beat;
    logic [15:0] m_cur;
    int          m_bc;
    logic        m_ovf;
    int          m_dc;

    zc_event_serializer #(.TS_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .zero_mask_in   (zero_mask_in),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_time       (evt_time),
        .evt_last       (evt_last),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef ZC_EVT_DROPCNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    function automatic int low(input logic [15:0] m);
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_beat = 0;
        m_cur = '0;
        m_bc = 0;
        m_ovf = 1'b0;
        m_dc = 0;
    endtask

    task automatic compare();
        chk("valid", {31'd0, evt_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("time", {24'd0, evt_time}, (m_beat * 16 + low(m_cur)) % 256);
            chk("last", {31'd0, evt_last}, ($countones(m_cur) == 1) ? 1 : 0);
        end
        chk("ovf", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef ZC_EVT_DROPCNT_EN
        chk("dropcnt", {16'd0, drop_count}, m_dc);
`endif
    endtask

    task automatic step(input logic v, input logic [15:0] m, input logic r, input logic c);
        logic acc, lst, pop, push, drop;
        ent_t e;
        valid_in = v;
        zero_mask_in = m;
        evt_ready = r;
        clear_overflow = c;
        @(posedge clk);
        acc  = m_valid && r;
        lst  = $countones(m_cur) == 1;
        pop  = (q.size() > 0) && (!m_valid || (acc && lst));
        push = v && (m != 0);
        drop = push && (q.size() == DEPTH) && !pop;
        if (acc) m_cur[low(m_cur)] = 1'b0;
        if (pop) begin
            e = q.pop_front();
            m_beat = e.beat;
            m_cur = e.mask;
            m_valid = 1'b1;
        end else if (acc && lst) m_valid = 1'b0;
        if (push && !drop) begin
            e.beat = m_bc;
            e.mask = m;
            q.push_back(e);
        end
        if (v) m_bc = (m_bc + 1) % (1 << TW);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (c) m_dc = drop ? 1 : 0;
        else if (drop && m_dc != 16'hFFFF) m_dc++;
        #1;
        compare();
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, evt_valid}, 0);
        chk("rst_time", {24'd0, evt_time}, 0);
        chk("rst_last", {31'd0, evt_last}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
`ifdef ZC_EVT_DROPCNT_EN
        chk("rst_dropcnt", {16'd0, drop_count}, 0);
`endif
        model_reset();
        valid_in = 1'b0;
        zero_mask_in = '0;
        evt_ready = 1'b0;
        clear_overflow = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rm;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // single event with latency of two cycles
        step(1, 16'h0000, 1, 0);
        step(1, 16'h0001, 1, 0);
        chk("lat_n1", {31'd0, evt_valid}, 0);
        step(0, 16'h0000, 1, 0);
        chk("lat_n2", {31'd0, evt_valid}, 1);
        chk("lat_time", {24'd0, evt_time}, 16);
        chk("lat_last", {31'd0, evt_last}, 1);
        step(0, 16'h0000, 1, 0);
        chk("lat_done", {31'd0, evt_valid}, 0);

        // four lanes of one beat on consecutive cycles
        do_reset();
        step(1, 16'h8421, 1, 0);
        step(0, 16'h0000, 1, 0);
        chk("b0_l0", {24'd0, evt_time}, 0);
        chk("b0_l0_last", {31'd0, evt_last}, 0);
        step(0, 16'h0000, 1, 0);
        chk("b0_l5", {24'd0, evt_time}, 5);
        step(0, 16'h0000, 1, 0);
        chk("b0_l10", {24'd0, evt_time}, 10);
        step(0, 16'h0000, 1, 0);
        chk("b0_l15", {24'd0, evt_time}, 15);
        chk("b0_l15_last", {31'd0, evt_last}, 1);
        step(0, 16'h0000, 1, 0);
        chk("b0_done", {31'd0, evt_valid}, 0);

        // backpressure holds the event stable
        do_reset();
        step(1, 16'h0003, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 16'h0000, 0, 0);
            chk("hold_valid", {31'd0, evt_valid}, 1);
            chk("hold_time", {24'd0, evt_time}, 0);
        end
        step(0, 16'h0000, 1, 0);
        chk("rel_time", {24'd0, evt_time}, 1);
        step(0, 16'h0000, 1, 0);
        chk("rel_done", {31'd0, evt_valid}, 0);

        // overflow with FIFO and output register full
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 16'hFFFF, 0, 0);
        chk("pre_ovf", {31'd0, overflow}, 0);
        step(1, 16'hFFFF, 0, 0);
        chk("ovf_set", {31'd0, overflow}, 1);
        step(1, 16'hFFFF, 0, 1);
        chk("ovf_clr_drop", {31'd0, overflow}, 1);
        step(0, 16'h0000, 0, 1);
        chk("ovf_clr", {31'd0, overflow}, 0);
        for (int i = 0; i < 150; i++) step(0, 16'h0000, 1, 0);
        chk("drain_done", {31'd0, evt_valid}, 0);

        // beat counter wrap
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 16'h0000, 1, 0);
        step(1, 16'h0002, 0, 0);
        step(0, 16'h0000, 0, 0);
        chk("wrap_time", {24'd0, evt_time}, 15 * 16 + 1);
        step(1, 16'h0001, 1, 0);
        step(0, 16'h0000, 1, 0);
        chk("wrap_next", {24'd0, evt_time}, 0);
        chk("wrap_next_valid", {31'd0, evt_valid}, 1);
        step(0, 16'h0000, 1, 0);

        // reset mid-stream with queued entries
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 16'h0001, 0, 0);
        chk("pre_rst_valid", {31'd0, evt_valid}, 1);
        do_reset();
        step(1, 16'h0004, 1, 0);
        step(0, 16'h0000, 1, 0);
        chk("post_rst_time", {24'd0, evt_time}, 2);
        step(0, 16'h0000, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rm = 16'h0000;
                3, 4, 5, 6: rm = 16'(1 << $urandom_range(0, 15));
                7: rm = 16'($urandom);
                default: rm = 16'($urandom & $urandom);
            endcase
            step($urandom_range(0, 3) != 0, rm, $urandom_range(0, 4) != 0, $urandom_range(0, 40) == 0);
        end
        for (int i = 0; i < 400; i++) step(0, 16'h0000, 1, 0);
        chk("final_empty", {31'd0, evt_valid}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/zc_event_serializer.md
# zc_event_serializer

Consumes the per-cycle 16-bit zero-crossing masks produced by the zero-point mask stage and converts them into a serial stream of timestamped zero-crossing events, one event per handshake. Sits between mask generation and downstream event processing (pulse segmentation, DMA packing), decoupling the bursty, up-to-16-events-per-cycle mask rate from a one-event-per-cycle valid/ready consumer.

## Interface
- NUM_CHANNELS, 16, lanes per cycle (power of 2); lane 0 = earliest sample
- TS_WIDTH, 32, width of the beat (cycle) counter
- FIFO_DEPTH, 8, mask-entry FIFO depth (power of 2, ≥2)
- clk  input  1  system clock (78.125 MHz deserialized domain)
- rst  input  1  asynchronous, active-high reset
- valid_in  input  1  zero_mask_in is a valid beat
- zero_mask_in  input  NUM_CHANNELS  bit i set = crossing at lane i of this beat
- evt_valid  output  1  event available
- evt_ready  input  1  consumer accepts event
- evt_time  output  TS_WIDTH+LANE_W  {beat_index, lane}, absolute sample index mod 2^(TS_WIDTH+LANE_W)
- evt_last  output  1  event is the last set lane of its beat
- overflow  output  1  sticky: a nonzero beat was dropped
- clear_overflow  input  1  clears overflow
- drop_count  output  16  dropped-beat count (only with ZC_EVT_DROPCNT_EN)

## Operation
- Beat counter: increments by 1 on every valid_in cycle, regardless of mask; wraps mod 2^TS_WIDTH. Beat index stored is the counter value before increment (first beat after reset = 0).
- Beats with valid_in=1 and mask=0 are counted, never stored.
- Nonzero beats pushed to FIFO as {beat_index, mask}. FIFO full and no pop this cycle: beat dropped, overflow set. Full with simultaneous pop: push accepted.
- Output register holds current entry {beat, residual_mask}. evt_time lane = index of lowest set residual bit (earliest first). On evt_valid&&evt_ready: clear that bit; if residual becomes zero, pop next FIFO entry into output register same cycle (no bubble).
- evt_last = residual has exactly one bit set.
- Output states: EMPTY (evt_valid=0), PRESENT (evt_valid=1). EMPTY→PRESENT when FIFO nonempty; PRESENT→EMPTY on accept of last bit with FIFO empty.
- AXI-stream rules: evt_valid never deasserts and evt_time/evt_last never change while evt_valid&&!evt_ready; evt_valid does not depend on evt_ready.
- overflow: set and clear_overflow in same cycle → set wins.

## Timing
- Reset values: evt_valid=0, evt_time=0, evt_last=0, overflow=0, drop_count=0; beat counter=0, FIFO empty.
- Latency: nonzero beat at cycle N, FIFO empty, output EMPTY → evt_valid=1 at N+2.
- Throughput: 1 event/cycle with evt_ready held high; sustained input beyond 1 crossing/beat average eventually overflows.
- Reset mid-stream: all entries and pending events discarded immediately, counter restarts at 0.

## Configuration
- ZC_EVT_DROPCNT_EN defined: drop_count port present, increments per dropped beat, saturates at 0xFFFF, cleared by clear_overflow (same-cycle drop: result = 1).
- Undefined: port and counter absent; overflow flag unchanged.

## Structure
- Package zc_pkg: NUM_CHANNELS, LANE_W=$clog2(NUM_CHANNELS), typedef zc_entry_t {beat, mask}, typedef zc_event_t {time, last}.
- One sub-module: zc_mask_fifo (synchronous FIFO, registered full/empty, same-cycle push/pop when full).
- Lowest-set-bit priority encoder is combinational inside the top.

## Test plan
- After reset, beats masks 0x0000,0x0001 with evt_ready=1 → single event evt_time=16 (beat 1, lane 0), evt_last=1, evt_valid two cycles after beat.
- One beat mask 0x8421 at beat 0 → events lane 0,5,10,15 on 4 consecutive cycles, evt_last only on lane 15.
- evt_ready=0 for 10 cycles during pending event → evt_valid, evt_time stable; release → stream continues, no loss.
- evt_ready=0, push 9 beats mask 0xFFFF (FIFO_DEPTH=8, one in output reg) then a 10th → overflow=1, drop_count=1; assert clear_overflow with concurrent drop → overflow stays 1.
- Preload counter via 2^TS_WIDTH−1 idle beats (small TS_WIDTH=4 build), then mask 0x0002 → evt_time = 15*16+1, next beat wraps to beat 0.
- Assert rst while 3 entries queued and evt_valid=1 → outputs return to reset values same cycle; next beat timestamp restarts at 0.
